// File: rtl/q_frame_accumulator.sv
// rtl/q_frame_accumulator.sv - sequences q_measurement and sums N_SAMPLES results per frame
// Optional feature macro: Q_ACC_SATURATE_EN (saturating frame sum instead of wrap-around).
module q_frame_accumulator #(
  parameter int WIDTH     = 10,
  parameter int N_SAMPLES = 4,
  parameter int ACC_WIDTH = 12,
  parameter int GAP       = 2,
  parameter int TO_WIDTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_ready,
  input  logic [WIDTH-1:0]     i_measured_q,
  output logic                 o_start,
  output logic [ACC_WIDTH-1:0] o_acc_q,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ack,
  output logic [7:0]           o_sample_idx,
  output logic                 o_timeout_err
);

  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [GW-1:0]       GAP_C    = GW'(GAP);
  // Last watchdog value before expiry: MEASURE lasts at most 2^TO_WIDTH-1 cycles.
  localparam logic [TO_WIDTH-1:0] WD_LAST  = TO_WIDTH'((2 ** TO_WIDTH) - 2);
  localparam logic [7:0]          IDX_LAST = 8'(N_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GW-1:0]         r_gap;
  logic [TO_WIDTH-1:0]   r_wd;
  logic [WIDTH-1:0]      r_cap;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [7:0]            r_idx;
  logic                  r_timeout;
  logic                  r_start;
  logic                  r_valid;

  logic                  w_gap_done;
  logic                  w_wd_expired;
  logic                  w_last;
  logic                  w_frame_clear;
  logic                  w_cap_load;
  logic [WIDTH-1:0]      w_cap_val;
  logic                  w_timeout_set;
  logic                  w_acc_add;
  logic                  w_idx_inc;
  logic [ACC_WIDTH-1:0]  w_acc_next;

  assign w_gap_done   = (r_gap >= GAP_C);
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_last       = (r_idx == IDX_LAST);

`ifdef Q_ACC_SATURATE_EN
  logic [ACC_WIDTH:0] w_sum;
  assign w_sum      = {1'b0, r_acc} + (ACC_WIDTH + 1)'(r_cap);
  assign w_acc_next = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
`else
  assign w_acc_next = r_acc + ACC_WIDTH'(r_cap);
`endif

  // State register; reset drops start immediately so the front end re-arms.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; ARM also waits for a stale ready to clear.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_enable) w_state_nxt = S_ARM;
      S_ARM:     if (w_gap_done && !i_ready) w_state_nxt = S_MEASURE;
      S_MEASURE: if (i_ready || w_wd_expired) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_last ? S_DONE : S_ARM;
      S_DONE:    if (i_acc_ack) w_state_nxt = i_enable ? S_ARM : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls per state; ready wins over a simultaneous watchdog expiry.
  always_comb begin
    w_frame_clear = 1'b0;
    w_cap_load    = 1'b0;
    w_cap_val     = '0;
    w_timeout_set = 1'b0;
    w_acc_add     = 1'b0;
    w_idx_inc     = 1'b0;
    case (r_state)
      S_IDLE:    w_frame_clear = i_enable;
      S_MEASURE: begin
        w_cap_load    = i_ready || w_wd_expired;
        w_cap_val     = i_ready ? i_measured_q : '0;
        w_timeout_set = !i_ready && w_wd_expired;
      end
      S_CAPTURE: begin
        w_acc_add = 1'b1;
        w_idx_inc = !w_last;
      end
      S_DONE:    w_frame_clear = i_acc_ack && i_enable;
      default:   w_frame_clear = 1'b0;
    endcase
  end

  // Counters, capture/accumulate registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gap     <= '0;
      r_wd      <= '0;
      r_cap     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      if (r_state != S_ARM)  r_gap <= '0;
      else if (!w_gap_done)  r_gap <= r_gap + 1'b1;
      if (r_state != S_MEASURE) r_wd <= '0;
      else                      r_wd <= r_wd + 1'b1;
      if (w_cap_load) r_cap <= w_cap_val;
      if (w_frame_clear) begin
        r_acc     <= '0;
        r_idx     <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_acc_add)     r_acc     <= w_acc_next;
        if (w_idx_inc)     r_idx     <= r_idx + 1'b1;
        if (w_timeout_set) r_timeout <= 1'b1;
      end
      r_start <= (w_state_nxt == S_MEASURE);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign o_start       = r_start;
  assign o_acc_q       = r_acc;
  assign o_acc_valid   = r_valid;
  assign o_sample_idx  = r_idx;
  assign o_timeout_err = r_timeout;

endmodule

// File: tb/tb_q_frame_accumulator.sv
// tb/tb_q_frame_accumulator.sv - randomized self-checking bench for q_frame_accumulator
module tb_q_frame_accumulator;

  localparam int W    = 10;
  localparam int N    = 4;
  localparam int AW   = 11;
  localparam int GAP  = 2;
  localparam int TOW  = 8;
  localparam int MAXA = (1 << AW) - 1;
  localparam int WD_CYC = (1 << TOW) - 1;

  logic          clk = 1'b0;
  logic          rst, enable, ready, acc_ack;
  logic [W-1:0]  measured_q;
  logic          start, acc_valid, timeout_err;
  logic [AW-1:0] acc_q;
  logic [7:0]    sample_idx;

  typedef struct {
    int unsigned val;
    int unsigned lat;
    bit          never;
    int unsigned stale;
  } meas_t;

  meas_t plan[$];
  meas_t fr[N];
  meas_t cur;

  int n_chk, n_fail;
  int cyc = 0;
  int pulses, ref_cyc;
  bit ref_armed;

  q_frame_accumulator #(.WIDTH(W), .N_SAMPLES(N), .ACC_WIDTH(AW), .GAP(GAP), .TO_WIDTH(TOW)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_ready(ready), .i_measured_q(measured_q),
    .o_start(start), .o_acc_q(acc_q), .o_acc_valid(acc_valid), .i_acc_ack(acc_ack),
    .o_sample_idx(sample_idx), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_fr(input int i, input int unsigned val, input int unsigned lat,
                        input bit never, input int unsigned stale);
    fr[i].val = val; fr[i].lat = lat; fr[i].never = never; fr[i].stale = stale;
  endtask

  // Frame sum from the plain arithmetic rule: timed-out samples count as 0.
  function automatic int unsigned model_sum();
    int unsigned s = 0;
    for (int i = 0; i < N; i++) s += fr[i].never ? 0 : fr[i].val;
`ifdef Q_ACC_SATURATE_EN
    if (s > MAXA) s = MAXA;
`else
    s = s % (MAXA + 1);
`endif
    return s;
  endfunction

  task automatic run_frame(input int hold, input string tag);
    int unsigned exp_sum;
    bit          exp_to;
    int          w;
    exp_sum = model_sum();
    exp_to  = 1'b0;
    for (int i = 0; i < N; i++) begin
      plan.push_back(fr[i]);
      if (fr[i].never) exp_to = 1'b1;
    end
    pulses = 0;
    w = 0;
    while (!acc_valid && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, acc_valid, 1);
    if (acc_valid) begin
      check({tag, "_sum"}, acc_q, exp_sum);
      check({tag, "_to"}, timeout_err, exp_to);
      check({tag, "_pulses"}, pulses, N);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, "_hold_sum"}, acc_q, exp_sum);
        check({tag, "_hold_start"}, start, 0);
        check({tag, "_hold_valid"}, acc_valid, 1);
        check({tag, "_hold_to"}, timeout_err, exp_to);
      end
      acc_ack   = 1'b1;
      ref_cyc   = cyc + 1;
      ref_armed = 1'b1;
      @(negedge clk);
      acc_ack = 1'b0;
      check({tag, "_valid_drop"}, acc_valid, 0);
    end
  endtask

  // Front-end model of q_measurement plus start/ready protocol monitor.
  initial begin
    int cnt, stale_cnt, hi_cnt, lo_cnt;
    bit prev_start;
    ready = 1'b0; measured_q = '0; prev_start = 1'b0;
    cnt = 0; stale_cnt = 0; hi_cnt = 0; lo_cnt = 100;
    cur.val = 0; cur.lat = 1; cur.never = 1'b0; cur.stale = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready = 1'b0; prev_start = 1'b0; stale_cnt = 0; hi_cnt = 0; lo_cnt = 100;
      end else begin
        if (start && !prev_start) begin
          check("stale_ready", ready, 0);
          check("start_gap", lo_cnt >= GAP + 1, 1);
          check("sample_idx", sample_idx, pulses);
          if (pulses == 0) check("to_cleared", timeout_err, 0);
          if (ref_armed) begin
            check("restart_gap", (cyc - ref_cyc) >= GAP + 1, 1);
            ref_armed = 1'b0;
          end
          pulses++;
          if (plan.size() > 0) cur = plan.pop_front();
          else begin
            cur.val = $urandom_range(0, 1023); cur.lat = 1; cur.never = 1'b0; cur.stale = 0;
          end
          cnt = cur.lat;
          hi_cnt = 0;
        end
        if (!start && prev_start && cur.never) check("wdog_len", hi_cnt, WD_CYC);
        if (start) begin
          hi_cnt++;
          lo_cnt = 0;
          if (!cur.never) begin
            if (cnt > 0) cnt--;
            if (cnt == 0) begin
              ready = 1'b1;
              measured_q = W'(cur.val);
            end
          end
          stale_cnt = cur.stale;
        end else begin
          lo_cnt++;
          if (ready) begin
            if (stale_cnt == 0) ready = 1'b0;
            else stale_cnt--;
          end
        end
        if (!ready) measured_q = W'($urandom);
        prev_start = start;
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; enable = 1'b0; acc_ack = 1'b0;
    n_chk = 0; n_fail = 0; pulses = 0; ref_cyc = 0; ref_armed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_start", start, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_acc", acc_q, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_to", timeout_err, 0);
    rst = 1'b0;

    set_fr(0, 30, 2, 0, 0); set_fr(1, 60, 2, 0, 0);
    set_fr(2, 90, 2, 0, 0); set_fr(3, 120, 2, 0, 0);
    enable = 1'b1;
    run_frame(0, "normal");

    for (int i = 0; i < N; i++) set_fr(i, $urandom_range(1, 1023), 3, 0, 5);
    run_frame(0, "stale");

    for (int i = 0; i < N; i++) set_fr(i, $urandom_range(0, 500), 2, (i == 2), 0);
    run_frame(10, "wdog");

    for (int i = 0; i < N; i++) set_fr(i, $urandom_range(0, 1023), 1, 0, 0);
    run_frame(0, "after_wdog");

    for (int i = 0; i < N; i++) set_fr(i, 1023, 1, 0, 0);
    run_frame(2, "sat");

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        set_fr(i, $urandom_range(0, 1023), $urandom_range(1, 8),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      run_frame($urandom_range(0, 4), "rand");
    end

    for (int i = 0; i < N; i++) begin
      set_fr(i, 100 + i, 20, 0, 0);
      plan.push_back(fr[i]);
    end
    pulses = 0;
    w = 0;
    while (!start && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("rstmid_in_measure", start, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_start", start, 0);
    check("rstmid_valid", acc_valid, 0);
    check("rstmid_idx", sample_idx, 0);
    check("rstmid_acc", acc_q, 0);
    @(negedge clk);
    @(negedge clk);
    plan.delete();
    ref_armed = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_fr(i, $urandom_range(0, 1023), 2, 0, 0);
    run_frame(0, "post_rst");

    for (int i = 0; i < N; i++) set_fr(i, $urandom_range(0, 1023), 2, 0, 0);
    fork
      run_frame(0, "en_fall");
      begin
        repeat (8) @(negedge clk);
        enable = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("idle_pulses", pulses, N);
    check("idle_start", start, 0);
    check("idle_valid", acc_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
